// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the 5-stage MIPS pipeline: launches mult/div ops,
// counts the busy window, commits results to HI/LO and raises the D-stage stall.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  output logic        Start,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [31:0]     r_pend_hi, r_pend_lo, w_pend_hi_next, w_pend_lo_next;
  logic            r_pend_we, w_pend_we_next;
  logic [31:0]     r_hi, r_lo, w_hi_next, w_lo_next;

  // E-stage decode
  logic       w_e_rtype, w_e_mul, w_e_div, w_e_md, w_e_mthi, w_e_mtlo;
  logic [5:0] w_e_funct;
  assign w_e_rtype = (IR_E[31:26] == 6'b000000);
  assign w_e_funct = IR_E[5:0];
  assign w_e_mul   = w_e_rtype & ((w_e_funct == F_MULT) | (w_e_funct == F_MULTU));
  assign w_e_div   = w_e_rtype & ((w_e_funct == F_DIV)  | (w_e_funct == F_DIVU));
  assign w_e_md    = w_e_mul | w_e_div;
  assign w_e_mthi  = w_e_rtype & (w_e_funct == F_MTHI);
  assign w_e_mtlo  = w_e_rtype & (w_e_funct == F_MTLO);

  // D-stage decode: anything that touches HI/LO must wait for the unit
  logic       w_d_md;
  logic [5:0] w_d_funct;
  assign w_d_funct = IR_D[5:0];
  assign w_d_md = (IR_D[31:26] == 6'b000000) &
                  ((w_d_funct == F_MULT) | (w_d_funct == F_MULTU) |
                   (w_d_funct == F_DIV)  | (w_d_funct == F_DIVU)  |
                   (w_d_funct == F_MFHI) | (w_d_funct == F_MFLO)  |
                   (w_d_funct == F_MTHI) | (w_d_funct == F_MTLO));

  assign Busy     = (r_state == S_RUN);
  assign Start    = w_e_md & ~Busy;
  assign Stall_MD = w_d_md & (Start | Busy);
  assign HI       = r_hi;
  assign LO       = r_lo;

  // Multiply: low 64 bits of the 64x64 product of the extended operands
  logic        w_signed_op;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  assign w_signed_op = ~w_e_funct[0];
  assign w_a_ext = {{32{w_signed_op & RS_E[31]}}, RS_E};
  assign w_b_ext = {{32{w_signed_op & RT_E[31]}}, RT_E};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes, then restore signs; avoids the signed-overflow corner
  logic        w_neg_a, w_neg_b, w_div_zero;
  logic [31:0] w_abs_a, w_abs_b, w_divisor, w_q_mag, w_r_mag, w_quot, w_rem;
  assign w_neg_a    = w_signed_op & RS_E[31];
  assign w_neg_b    = w_signed_op & RT_E[31];
  assign w_abs_a    = w_neg_a ? (~RS_E + 32'd1) : RS_E;
  assign w_abs_b    = w_neg_b ? (~RT_E + 32'd1) : RT_E;
  assign w_div_zero = (RT_E == 32'd0);
  assign w_divisor  = w_div_zero ? 32'd1 : w_abs_b;
  assign w_q_mag    = w_abs_a / w_divisor;
  assign w_r_mag    = w_abs_a % w_divisor;
  assign w_quot     = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem      = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pend_hi_next = r_pend_hi;
    w_pend_lo_next = r_pend_lo;
    w_pend_we_next = r_pend_we;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_next = S_RUN;
          if (w_e_mul) begin
            w_cnt_next     = CW'(MULT_CYCLES);
            w_pend_hi_next = w_prod[63:32];
            w_pend_lo_next = w_prod[31:0];
            w_pend_we_next = 1'b1;
          end else begin
            w_cnt_next     = CW'(DIV_CYCLES);
            w_pend_hi_next = w_rem;
            w_pend_lo_next = w_quot;
            w_pend_we_next = ~w_div_zero;
          end
        end else if (w_e_mthi) begin
          w_hi_next = RS_E;
        end else if (w_e_mtlo) begin
          w_lo_next = RS_E;
        end
      end
      S_RUN: begin
        if (r_cnt > CW'(1)) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          if (r_pend_we) begin
            w_hi_next = r_pend_hi;
            w_lo_next = r_pend_lo;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pend_hi <= w_pend_hi_next;
      r_pend_lo <= w_pend_lo_next;
      r_pend_we <= w_pend_we_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
    end
  end

endmodule
